// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM encoding, slot counts, phase indices,
// direction constants and the quarter-period divider computation.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND_BYTE,
    ST_GET_ACK,
    ST_RESTART,
    ST_RECV_BYTE,
    ST_SEND_NACK,
    ST_STOP
  } state_t;

  localparam int WR_SLOTS = 29;
  localparam int RD_SLOTS = 39;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic int calc_div(
    input int clk_hz,
    input int scl_hz
  );
    return clk_hz / (4 * scl_hz);
  endfunction

  function automatic int slot_total(input logic rw);
    return (rw == RW_READ) ? RD_SLOTS : WR_SLOTS;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period divider: pulses tick on the last clock of every DIV-clock
// phase and steps a 2-bit phase index; restart realigns to phase 0.
module i2c_tick_gen #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt   <= '0;
      r_phase <= 2'd0;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick  = (r_cnt == LAST);
  assign phase = r_phase;

endmodule

// File: rtl/i2c_master_core.sv
// Byte-level I2C initiator: one register write or one repeated-START
// register read per request, open-drain SCL/SDA enables.
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       core_busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       ack_error,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int DIV = calc_div(CLK_FREQ, I2C_FREQ);

  state_t     r_state;
  logic       r_busy;
  logic       r_rd_valid;
  logic       r_ack_err;
  logic       r_scl;
  logic       r_sda;
  logic [7:0] r_rd_data;
  logic       r_rw;
  logic [6:0] r_saddr;
  logic [7:0] r_raddr;
  logic [7:0] r_wdata;
  logic [6:0] r_shift;
  logic [2:0] r_bit;
  logic [1:0] r_byte;

  logic       w_restart;
  logic       w_tick;
  logic [1:0] w_phase;
  logic [7:0] w_load;

  assign w_restart = (r_state == ST_IDLE) && data_valid;

  i2c_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(w_restart),
    .tick   (w_tick),
    .phase  (w_phase)
  );

  // Byte loaded when the current slot hands over to SEND_BYTE
  always_comb begin
    w_load = {r_saddr, RW_WRITE};
    unique case (1'b1)
      (r_state == ST_RESTART):
        w_load = {r_saddr, RW_READ};
      (r_state == ST_GET_ACK && r_byte == 2'd0):
        w_load = r_raddr;
      (r_state == ST_GET_ACK && r_byte != 2'd0):
        w_load = r_wdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    r_rd_valid <= 1'b0;
    if (rst) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_ack_err <= 1'b0;
      r_scl     <= 1'b0;
      r_sda     <= 1'b0;
      r_rd_data <= '0;
      r_rw      <= RW_WRITE;
      r_saddr   <= '0;
      r_raddr   <= '0;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (data_valid) begin
        r_rw      <= rw;
        r_saddr   <= slave_addr;
        r_raddr   <= reg_addr;
        r_wdata   <= reg_data;
        r_ack_err <= 1'b0;
        r_busy    <= 1'b1;
        r_state   <= ST_START;
        r_scl     <= 1'b0;
        r_sda     <= 1'b0;
      end
    end else if (w_tick) begin
      unique case (w_phase)
        PH_0: r_scl <= 1'b0;
        PH_1: begin
          if (r_state == ST_START || r_state == ST_RESTART)
            r_sda <= 1'b1;
          if (r_state == ST_STOP)
            r_sda <= 1'b0;
          if (r_state == ST_GET_ACK && sda_in)
            r_ack_err <= 1'b1;
          if (r_state == ST_RECV_BYTE)
            r_rd_data <= {r_rd_data[6:0], sda_in};
        end
        PH_2: begin
          if (r_state != ST_STOP)
            r_scl <= 1'b1;
        end
        PH_3: begin
          // Slot boundary: pick the next slot and its phase-0 levels
          r_scl <= 1'b1;
          case (r_state)
            ST_START, ST_RESTART: begin
              r_state <= ST_SEND_BYTE;
              r_shift <= w_load[6:0];
              r_sda   <= ~w_load[7];
              r_bit   <= '0;
              r_byte  <= (r_state == ST_RESTART) ? 2'd2 : 2'd0;
            end
            ST_SEND_BYTE: begin
              if (r_bit == 3'd7) begin
                r_state <= ST_GET_ACK;
                r_sda   <= 1'b0;
              end else begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {r_shift[5:0], 1'b0};
                r_sda   <= ~r_shift[6];
              end
            end
            ST_GET_ACK: begin
              if (r_ack_err) begin
                r_state <= ST_STOP;
                r_sda   <= 1'b1;
              end else if (r_byte == 2'd0 ||
                           (r_byte == 2'd1 && r_rw == RW_WRITE)) begin
                r_state <= ST_SEND_BYTE;
                r_shift <= w_load[6:0];
                r_sda   <= ~w_load[7];
                r_bit   <= '0;
                r_byte  <= r_byte + 2'd1;
              end else if (r_byte == 2'd1) begin
                r_state <= ST_RESTART;
                r_scl   <= 1'b0;
                r_sda   <= 1'b0;
              end else if (r_rw == RW_READ) begin
                r_state <= ST_RECV_BYTE;
                r_sda   <= 1'b0;
                r_bit   <= '0;
              end else begin
                r_state <= ST_STOP;
                r_sda   <= 1'b1;
              end
            end
            ST_RECV_BYTE: begin
              if (r_bit == 3'd7)
                r_state <= ST_SEND_NACK;
              else
                r_bit <= r_bit + 3'd1;
            end
            ST_SEND_NACK: begin
              r_state <= ST_STOP;
              r_sda   <= 1'b1;
            end
            ST_STOP: begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_scl      <= 1'b0;
              r_sda      <= 1'b0;
              r_rd_valid <= (r_rw == RW_READ) && !r_ack_err;
            end
            default: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_scl   <= 1'b0;
              r_sda   <= 1'b0;
            end
          endcase
        end
      endcase
    end
  end

  assign core_busy = r_busy;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign ack_error = r_ack_err;
  assign scl_oe    = r_scl;
  assign sda_oe    = r_sda;

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core with a bus responder that logs
// START/STOP events and 9-bit frames as seen on the wired-AND bus.
module tb_i2c_master_core;

  localparam logic [9:0] T_S = 10'h200;
  localparam logic [9:0] T_P = 10'h300;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic       rw;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       core_busy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ack_error;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  always #5 clk = ~clk;

  i2c_master_core #(
    .CLK_FREQ(400),
    .I2C_FREQ(25)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .rw        (rw),
    .slave_addr(slave_addr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .core_busy (core_busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .ack_error (ack_error),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_in    (sda_in)
  );

  logic       scl_bus;
  logic       sda_bus;
  logic       p_scl;
  logic       p_sda;
  logic       r_pull;
  logic       r_tx;
  logic       r_is_addr;
  logic       r_nack_addr;
  logic [7:0] r_sh;
  logic [7:0] tx_byte;
  int         bitn;
  logic [9:0] log_q[$];
  logic [9:0] exp_q[$];

  assign scl_bus = !scl_oe;
  assign sda_bus = !(sda_oe | r_pull);
  assign sda_in  = sda_bus;

  always @(negedge clk) begin
    p_scl <= scl_bus;
    p_sda <= sda_bus;
    if (rst) begin
      r_pull    <= 1'b0;
      r_tx      <= 1'b0;
      r_is_addr <= 1'b0;
      bitn      <= 0;
      p_scl     <= 1'b1;
      p_sda     <= 1'b1;
    end else if (p_scl && scl_bus && p_sda && !sda_bus) begin
      log_q.push_back(T_S);
      bitn      <= 0;
      r_is_addr <= 1'b1;
      r_tx      <= 1'b0;
    end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
      log_q.push_back(T_P);
      bitn      <= 0;
      r_is_addr <= 1'b0;
      r_tx      <= 1'b0;
    end else if (!p_scl && scl_bus) begin
      if (bitn < 8) begin
        r_sh <= {r_sh[6:0], sda_bus};
        bitn <= bitn + 1;
      end else begin
        log_q.push_back({1'b0, r_sh, sda_bus});
        bitn      <= 0;
        r_tx      <= r_is_addr && r_sh[0] && !sda_bus;
        r_is_addr <= 1'b0;
      end
    end else if (p_scl && !scl_bus) begin
      if (bitn == 8)
        r_pull <= r_tx ? 1'b0 : !(r_is_addr && r_nack_addr);
      else if (r_tx)
        r_pull <= !tx_byte[7-bitn];
      else
        r_pull <= 1'b0;
    end
  end

  int         rv_cnt = 0;
  logic [7:0] rv_data;
  logic       rv_busy;

  always @(negedge clk) begin
    if (rd_valid) begin
      rv_cnt  <= rv_cnt + 1;
      rv_data <= rd_data;
      rv_busy <= core_busy;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] tok(
    input logic [7:0] b,
    input logic       a
  );
    return {1'b0, b, a};
  endfunction

  task automatic req(
    input logic       w_rw,
    input logic [6:0] sa,
    input logic [7:0] ra,
    input logic [7:0] wd
  );
    @(negedge clk);
    rw         = w_rw;
    slave_addr = sa;
    reg_addr   = ra;
    reg_data   = wd;
    data_valid = 1'b1;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (core_busy) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int chg_at, output int n);
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == chg_at) begin
        slave_addr = 7'h50;
        reg_addr   = 8'h11;
        reg_data   = 8'hC3;
      end
      if (!core_busy) break;
      n++;
    end
  endtask

  task automatic exp_write(
    input logic [6:0] sa,
    input logic [7:0] ra,
    input logic [7:0] wd
  );
    exp_q.push_back(T_S);
    exp_q.push_back(tok({sa, 1'b0}, 1'b0));
    exp_q.push_back(tok(ra, 1'b0));
    exp_q.push_back(tok(wd, 1'b0));
    exp_q.push_back(T_P);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < log_q.size())
        chk($sformatf("%s_tok%0d", tag, i), log_q[i], exp_q[i]);
    log_q.delete();
    exp_q.delete();
  endtask

  int lat;
  int n;

  initial begin
    rst         = 1'b1;
    data_valid  = 1'b0;
    rw          = 1'b0;
    slave_addr  = '0;
    reg_addr    = '0;
    reg_data    = '0;
    r_nack_addr = 1'b0;
    tx_byte     = 8'hA5;
    repeat (2) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", core_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ack_error", ack_error, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    rst = 1'b0;
    log_q.delete();

    req(1'b0, 7'h1D, 8'h2D, 8'h08);
    wait_busy(lat);
    data_valid = 1'b0;
    chk("wr_accept_lat", lat, 1);
    wait_idle(-1, n);
    chk("wr_busy_cycles", n, 464);
    chk("wr_ack_error", ack_error, 0);
    chk("wr_no_rd_valid", rv_cnt, 0);
    exp_write(7'h1D, 8'h2D, 8'h08);
    chk_log("wr");

    req(1'b1, 7'h1D, 8'h32, 8'h00);
    wait_busy(lat);
    data_valid = 1'b0;
    chk("rd_accept_lat", lat, 1);
    wait_idle(-1, n);
    chk("rd_busy_cycles", n, 624);
    chk("rd_valid_at_fall", rd_valid, 1);
    @(negedge clk);
    chk("rd_valid_one_cycle", rd_valid, 0);
    chk("rd_valid_count", rv_cnt, 1);
    chk("rd_valid_data", rv_data, 8'hA5);
    chk("rd_valid_busy_low", rv_busy, 0);
    chk("rd_data_hold", rd_data, 8'hA5);
    chk("rd_ack_error", ack_error, 0);
    exp_q.push_back(T_S);
    exp_q.push_back(tok(8'h3A, 1'b0));
    exp_q.push_back(tok(8'h32, 1'b0));
    exp_q.push_back(T_S);
    exp_q.push_back(tok(8'h3B, 1'b0));
    exp_q.push_back(tok(8'hA5, 1'b1));
    exp_q.push_back(T_P);
    chk_log("rd");

    r_nack_addr = 1'b1;
    req(1'b1, 7'h1D, 8'h32, 8'h00);
    wait_busy(lat);
    data_valid = 1'b0;
    wait_idle(-1, n);
    chk("nack_busy_cycles", n, 176);
    chk("nack_ack_error", ack_error, 1);
    @(negedge clk);
    chk("nack_no_rd_valid", rv_cnt, 1);
    chk("nack_ack_sticky", ack_error, 1);
    exp_q.push_back(T_S);
    exp_q.push_back(tok(8'h3A, 1'b1));
    exp_q.push_back(T_P);
    chk_log("nack");
    r_nack_addr = 1'b0;

    req(1'b0, 7'h1D, 8'h2D, 8'h08);
    wait_busy(lat);
    chk("held_accept_lat", lat, 1);
    chk("held_ack_cleared", ack_error, 0);
    wait_idle(100, n);
    chk("held_busy1_cycles", n, 464);
    wait_busy(lat);
    data_valid = 1'b0;
    chk("held_gap", lat, 1);
    wait_idle(-1, n);
    chk("held_busy2_cycles", n, 464);
    exp_write(7'h1D, 8'h2D, 8'h08);
    exp_write(7'h50, 8'h11, 8'hC3);
    chk_log("held");

    req(1'b0, 7'h1D, 8'h2D, 8'h08);
    wait_busy(lat);
    data_valid = 1'b0;
    repeat (216) @(negedge clk);
    chk("mid_sda_oe_bit4", sda_oe, 1);
    chk("mid_scl_oe_high", scl_oe, 0);
    chk("mid_busy", core_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_scl_oe", scl_oe, 0);
    chk("mrst_sda_oe", sda_oe, 0);
    chk("mrst_busy", core_busy, 0);
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_ack_error", ack_error, 0);
    chk("mrst_rd_data", rd_data, 8'h00);
    repeat (3) @(negedge clk);
    log_q.delete();

    req(1'b0, 7'h1D, 8'h2D, 8'h08);
    wait_busy(lat);
    data_valid = 1'b0;
    chk("post_accept_lat", lat, 1);
    wait_idle(-1, n);
    chk("post_busy_cycles", n, 464);
    chk("post_ack_error", ack_error, 0);
    exp_write(7'h1D, 8'h2D, 8'h08);
    chk_log("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_core.md
# i2c_master_core

Byte-level I2C initiator that executes register write and register read requests from the sensor controller and drives the open-drain SCL/SDA pins. It sits between the controller FSM and the board I2C pads. Per request it performs one complete transaction: a single-register write, or a single-register read using a repeated START. It returns the read byte, or an acknowledge error, to the requester.

## Interface
- `CLK_FREQ`, 50_000_000: system clock in Hz.
- `I2C_FREQ`, 100_000: SCL frequency in Hz. `DIV = CLK_FREQ/(4*I2C_FREQ)` must be an integer ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `data_valid`  in  1  request strobe, level-sampled.
- `rw`  in  1  0 = write, 1 = read.
- `slave_addr`  in  7  7-bit target address.
- `reg_addr`  in  8  target register.
- `reg_data`  in  8  write data; ignored on read.
- `core_busy`  out  1  transaction in progress.
- `rd_data`  out  8  last byte read.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid in that cycle.
- `ack_error`  out  1  sticky; the target NACKed in the last transaction.
- `scl_oe`  out  1  1 = pull SCL low; 0 = release SCL.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release SDA.
- `sda_in`  in  1  SDA pad level.

## Operation
- **Reset values:** `core_busy`, `rd_valid`, `ack_error`, `scl_oe`, `sda_oe` = 0; `rd_data` = 0x00; state IDLE.
- **Accept:** in IDLE with `data_valid`=1, latch `rw`, `slave_addr`, `reg_addr`, `reg_data`. Clear `ack_error` and set `core_busy` on the next edge. While busy, `data_valid` is ignored.
- **Bus timing:** the transaction is a sequence of slots. Each slot is 4 phases of `DIV` clocks, with the tick divider restarted at acceptance.
  - Bit slot: SCL low in phases 0 and 3, high in phases 1 and 2. SDA changes only at the start of phase 0. `sda_in` is sampled on the last clock of phase 1.
- **Write sequence:** START, `{slave_addr,0}`+ACK, `reg_addr`+ACK, `reg_data`+ACK, STOP.
  - 29 slots total.
- **Read sequence:** START, `{slave_addr,0}`+ACK, `reg_addr`+ACK, START (repeated), `{slave_addr,1}`+ACK, 8 data bits, master NACK (SDA released), STOP.
  - 39 slots total.
- **START slot:** phases 0–1 release both lines; phase 2 SDA low; phase 3 SCL low.
- **STOP slot:** phase 0 SCL low, SDA low; phase 1 SCL high; phases 2–3 SDA released.
- **Data order:** bytes are sent MSB first. Received bits shift into `rd_data` MSB first.
- **ACK check:** `sda_in`=1 in any ACK slot sets `ack_error` and jumps to the STOP slot. No further bytes are sent and `rd_valid` is not pulsed.
- **FSM states:**
  - IDLE → START on accept.
  - START → SEND_BYTE.
  - SEND_BYTE → GET_ACK.
  - GET_ACK → next SEND_BYTE, RESTART, RECV_BYTE, or STOP (including the NACK abort).
  - RESTART → SEND_BYTE.
  - RECV_BYTE → SEND_NACK → STOP.
  - STOP → IDLE.
- **Read completion:** `rd_valid` pulses on the cycle `core_busy` falls, only for error-free reads.
- **Reset mid-transaction:** on the next edge both lines are released, all outputs take their reset values, and the state returns to IDLE. No STOP is generated.
- **Clock stretching:** not supported. SCL is never sampled.

## Timing
- Acceptance → `core_busy`=1: 1 cycle.
- Slot count:
  - `core_busy` stays high for exactly 29·4·`DIV` cycles (write) or 39·4·`DIV` cycles (read).
  - At defaults (`DIV`=125) this is 14 500 / 19 500 cycles.
  - A NACK abort shortens this: the next slot after the failing ACK slot is STOP.
- The first START-slot phase begins on the cycle `core_busy` rises.
- **Back-to-back requests:** with `data_valid` held high, `core_busy` is low for exactly 1 cycle between transactions.
- **Registered outputs:** all outputs are registered. There is no combinational path from `data_valid` to `core_busy`.

## Structure
- **Package `i2c_pkg`:**
  - FSM state encoding.
  - Slot counts (WR_SLOTS=29, RD_SLOTS=39).
  - Phase indices.
  - `RW_WRITE` / `RW_READ` constants.
  - The `DIV` computation function.
- **Sub-module `i2c_tick_gen`:** quarter-period divider.
  - Inputs: `clk`, `rst`, `restart`.
  - Outputs: `tick` (1-cycle pulse every `DIV` clocks) and a 2-bit `phase`.
  - Shared by future I2C blocks.

## Test plan
Bench parameters: `CLK_FREQ`=400, `I2C_FREQ`=25 (`DIV`=4), with an I2C responder model on the bus.

- **Reset:** assert `rst` 2 cycles → `scl_oe`=`sda_oe`=`core_busy`=`rd_valid`=`ack_error`=0, `rd_data`=0x00.
- **Write:** rw=0, 0x1D/0x2D/0x08, responder ACKs → bus carries 0x3A, 0x2D, 0x08 then STOP; `core_busy` high for 464 cycles; `ack_error`=0.
- **Read:** rw=1, 0x1D/0x32, responder returns 0xA5 →
  - bus carries 0x3A, 0x32, repeated START, 0x3B, master NACK, STOP;
  - `rd_valid` pulses once with `rd_data`=0xA5;
  - `core_busy` high for 624 cycles.
- **Address NACK:** responder NACKs the address →
  - `ack_error`=1 and STOP follows the ACK slot;
  - `core_busy` high for 3·16+... = (1+9+1)·16 = 176 cycles;
  - no `rd_valid`;
  - the next accepted request clears `ack_error`.
- **Held `data_valid`:** hold `data_valid`=1 through two writes → second request accepted exactly 1 cycle after `core_busy` falls; inputs changed mid-transaction do not alter the bus bytes.
- **Reset mid-byte:** assert `rst` during `reg_addr` bit 4 → next edge all outputs at reset values; a following write completes correctly.
